// File: rtl/agc_pkg.sv
// Shared constants for the AGC fetch/decode path: EXTEND word, instruction field layout
// and basic opcode values.
package agc_pkg;

    localparam int unsigned INSTR_W = 15;

    localparam logic [INSTR_W-1:0] EXTEND_WORD = 15'o00006;

    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned OPCODE_W   = 3;
    localparam int unsigned QC_LSB     = 10;
    localparam int unsigned QC_W       = 2;
    localparam int unsigned PERIPH_BIT = 9;
    localparam int unsigned ADDR12_W   = 12;
    localparam int unsigned ADDR10_W   = 10;

    localparam logic [OPCODE_W-1:0] OP_TC    = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_CCS   = 3'd1;
    localparam logic [OPCODE_W-1:0] OP_INDEX = 3'd2;
    localparam logic [OPCODE_W-1:0] OP_XCH   = 3'd3;
    localparam logic [OPCODE_W-1:0] OP_CS    = 3'd4;
    localparam logic [OPCODE_W-1:0] OP_TS    = 3'd5;
    localparam logic [OPCODE_W-1:0] OP_AD    = 3'd6;
    localparam logic [OPCODE_W-1:0] OP_MASK  = 3'd7;

endpackage

// File: rtl/agc_sync_fifo.sv
// Synchronous FIFO with occupancy count and flush; DEPTH must be a power of two so the
// pointers wrap naturally.
module agc_sync_fifo #(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy tracking guarantees stale entries are never read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/agc_fetch_queue.sv
// AGC fetch/decode stage: queues memory words, swallows EXTEND prefixes and presents decoded
// fields via valid/ready. Optional odd-parity check on input words with AGC_PARITY_CHECK_EN.
module agc_fetch_queue
    import agc_pkg::*;
#(
    parameter int unsigned WORD_W = 15,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tp,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [WORD_W-1:0]          mem_word,
`ifdef AGC_PARITY_CHECK_EN
    input  logic                       mem_par,
`endif
    input  logic                       flush,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [2:0]                 opcode,
    output logic [1:0]                 qc,
    output logic                       periph,
    output logic [11:0]                addr12,
    output logic [9:0]                 addr10,
    output logic                       extracode,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       parity_err
);

    logic [INSTR_W-1:0] word_in, head;
    logic [INSTR_W-1:0] word_q;
    logic               dec_valid_q, ext_q, extracode_q;
    logic               full, empty, accept, par_ok, push, swallow, load;

    assign word_in = mem_word[WORD_W-1 -: INSTR_W];

`ifdef AGC_PARITY_CHECK_EN
    logic parity_err_q;

    assign par_ok = ^{mem_par, mem_word};

    always_ff @(posedge clk) begin
        if (!rst_n) parity_err_q <= 1'b0;
        else        parity_err_q <= accept & ~par_ok;
    end

    assign parity_err = parity_err_q;
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    assign mem_ready = ~full;
    assign accept    = tp & mem_valid & mem_ready;
    assign push      = accept & par_ok & ~flush;

    // An EXTEND at the head is dropped without waiting for the output register.
    assign swallow = ~empty & (head == EXTEND_WORD);
    assign load    = ~empty & (head != EXTEND_WORD) & (~dec_valid_q | dec_ready);

    agc_sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (swallow | load),
        .wdata_i (word_in),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            word_q      <= '0;
            dec_valid_q <= 1'b0;
            ext_q       <= 1'b0;
            extracode_q <= 1'b0;
        end else begin
            if (load) begin
                word_q      <= head;
                dec_valid_q <= 1'b1;
                extracode_q <= ext_q;
                ext_q       <= 1'b0;
            end else if (dec_ready) begin
                dec_valid_q <= 1'b0;
            end
            if (swallow) ext_q <= 1'b1;
        end
    end

    assign dec_valid = dec_valid_q;
    assign extracode = extracode_q;
    assign opcode    = word_q[OPCODE_LSB +: OPCODE_W];
    assign qc        = word_q[QC_LSB +: QC_W];
    assign periph    = word_q[PERIPH_BIT];
    assign addr12    = word_q[ADDR12_W-1:0];
    assign addr10    = word_q[ADDR10_W-1:0];

endmodule

// File: tb/tb_agc_fetch_queue.sv
// Directed bench for agc_fetch_queue; the parity step is included when AGC_PARITY_CHECK_EN
// is defined.
module tb_agc_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n, tp, mem_valid, mem_ready, flush, dec_valid, dec_ready;
    logic [14:0] mem_word;
    logic        mem_par;
    logic [2:0]  opcode;
    logic [1:0]  qc;
    logic        periph, extracode, parity_err;
    logic [11:0] addr12;
    logic [9:0]  addr10;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    agc_fetch_queue #(
        .WORD_W (15),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tp         (tp),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_word   (mem_word),
`ifdef AGC_PARITY_CHECK_EN
        .mem_par    (mem_par),
`endif
        .flush      (flush),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .opcode     (opcode),
        .qc         (qc),
        .periph     (periph),
        .addr12     (addr12),
        .addr10     (addr10),
        .extracode  (extracode),
        .count      (count),
        .parity_err (parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [14:0] w);
        mem_word  = w;
        mem_par   = ~(^w);
        mem_valid = 1'b1;
        tp        = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; dec_ready = 1'b0;
        drive(15'o12345);

        // Reset with a word offered every cycle
        repeat (3) step();
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_parity_err", parity_err, 0);
        rst_n = 1'b1; mem_valid = 1'b0;
        #1;
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_extracode", extracode, 0);

        // mem_valid without tp must not enqueue
        drive(15'o30017); tp = 1'b0;
        step();
        chk("no_tp_count", count, 0);

        // Latency
        tp = 1'b1; dec_ready = 1'b1;
        step();
        mem_valid = 1'b0;
        chk("lat_count_n", count, 1);
        chk("lat_valid_n", dec_valid, 0);
        step();
        chk("lat_valid_n1", dec_valid, 1);
        chk("lat_opcode", opcode, 3);
        chk("lat_qc", qc, 0);
        chk("lat_addr12", addr12, 12'o0017);
        chk("lat_extracode", extracode, 0);
        step();
        chk("lat_consumed", dec_valid, 0);

        // EXTEND prefix
        dec_ready = 1'b0;
        drive(15'o00006);
        step();
        drive(15'o40100);
        step();
        mem_valid = 1'b0;
        chk("ext_count", count, 1);
        chk("ext_not_presented", dec_valid, 0);
        step();
        chk("ext_valid", dec_valid, 1);
        chk("ext_opcode", opcode, 4);
        chk("ext_addr12", addr12, 12'o0100);
        chk("ext_extracode", extracode, 1);
        drive(15'o20005);
        step();
        mem_valid = 1'b0;
        chk("ext_hold_opcode", opcode, 4);
        chk("ext_hold_count", count, 1);
        dec_ready = 1'b1;
        step();
        chk("ext_next_opcode", opcode, 2);
        chk("ext_next_addr12", addr12, 12'o0005);
        chk("ext_next_extracode", extracode, 0);
        step();
        chk("ext_drained", dec_valid, 0);

        // Backpressure: five words into a four-entry queue plus output register
        dec_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(15'o10000 + 15'(i));
            step();
        end
        chk("bp_valid", dec_valid, 1);
        chk("bp_head", addr12, 1);
        chk("bp_count", count, 4);
        chk("bp_mem_ready", mem_ready, 0);
        drive(15'o10006);
        step();
        mem_valid = 1'b0;
        chk("bp_full_count", count, 4);
        dec_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            step();
            chk("bp_drain_addr", addr12, i);
            chk("bp_drain_count", count, 5 - i);
            chk("bp_drain_opcode", opcode, 1);
        end
        step();
        chk("bp_empty", dec_valid, 0);

        // Flush with same-cycle enqueue and a pending EXTEND
        dec_ready = 1'b0;
        drive(15'o00006);
        step();
        drive(15'o50007);
        step();
        chk("fl_pre_count", count, 1);
        drive(15'o60010); flush = 1'b1;
        step();
        flush = 1'b0; mem_valid = 1'b0;
        chk("fl_count", count, 0);
        chk("fl_valid", dec_valid, 0);
        drive(15'o70011); dec_ready = 1'b1;
        step();
        mem_valid = 1'b0;
        step();
        chk("fl_next_valid", dec_valid, 1);
        chk("fl_next_opcode", opcode, 7);
        chk("fl_next_addr10", addr10, 10'o011);
        chk("fl_next_extracode", extracode, 0);
        step();

`ifdef AGC_PARITY_CHECK_EN
        // Even total parity is rejected
        dec_ready = 1'b0;
        drive(15'o00001); mem_par = 1'b1;
        step();
        mem_valid = 1'b0;
        chk("par_err_pulse", parity_err, 1);
        chk("par_err_count", count, 0);
        step();
        chk("par_err_clear", parity_err, 0);
        drive(15'o00001); mem_par = 1'b0;
        step();
        mem_valid = 1'b0;
        chk("par_ok_err", parity_err, 0);
        chk("par_ok_count", count, 1);
`else
        chk("par_tied", parity_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
